// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 SPI byte serializer.
package ssd1306_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } spi_tx_state_t;

    localparam int SPI_CLK_DIV_DEFAULT = 4;
    localparam int SPI_BYTE_BITS       = 8;

endpackage

// File: rtl/ssd1306_spi_clk_div.sv
// SCLK phase generator: counts CLK_DIV cycles per phase while running,
// emits a one-cycle tick on the last cycle of each phase and toggles the
// phase level at that tick. Clear forces the low phase with a fresh count.
module ssd1306_spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic rstn_in,
    input  logic run_i,
    input  logic clear_i,
    output logic phase_end_o,
    output logic sclk_phase_o
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic       phase_q;

    assign phase_end_o  = run_i && (cnt_q == DIV_M1);
    assign sclk_phase_o = phase_q;

    // Phase counter; clear wins over run so every state change restarts low.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
        end else if (run_i) begin
            if (cnt_q == DIV_M1) begin
                cnt_q   <= 8'd0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_tx.sv
// SSD1306 SPI byte serializer, mode 0, MSB first, with CSn framing.
// Optional one-entry holding register enabled by SSD1306_SPI_TX_BUFFER_EN,
// which lets the next byte start immediately after a non-last byte.
module ssd1306_spi_tx
    import ssd1306_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       command_start_in,
    input  logic [7:0] command_in,
    input  logic       command_last_byte_in,
    output logic       command_ready_out,
    output logic       oled_csn,
    output logic       oled_sclk,
    output logic       oled_sdin
);

    spi_tx_state_t state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [SPI_BYTE_BITS-1:0] shreg_q, shreg_d;
    logic          last_q, last_d;
    logic          csn_q, csn_d;
    logic          sdin_q, sdin_d;

    logic          accept;
    logic          load;
    logic          src_vld;
    logic [SPI_BYTE_BITS-1:0] src_byte;
    logic          src_last;
    logic          phase_end;
    logic          sclk_phase;

    assign accept = command_start_in && command_ready_out;

`ifdef SSD1306_SPI_TX_BUFFER_EN
    logic                     buf_vld_q;
    logic [SPI_BYTE_BITS-1:0] buf_byte_q;
    logic                     buf_last_q;
    logic                     acc_q;

    // The cycle after any accept reads not-ready so a held start is taken once.
    assign command_ready_out = !buf_vld_q && !acc_q;
    // A fresh accept bypasses the buffer when the shifter can take it now.
    assign src_vld  = buf_vld_q || accept;
    assign src_byte = buf_vld_q ? buf_byte_q : command_in;
    assign src_last = buf_vld_q ? buf_last_q : command_last_byte_in;

    // Holding register: filled by an accept the shifter cannot take, drained on load.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            buf_vld_q  <= 1'b0;
            buf_byte_q <= '0;
            buf_last_q <= 1'b0;
            acc_q      <= 1'b0;
        end else begin
            acc_q <= accept;
            if (accept && !load) begin
                buf_vld_q  <= 1'b1;
                buf_byte_q <= command_in;
                buf_last_q <= command_last_byte_in;
            end else if (load) begin
                buf_vld_q <= 1'b0;
            end
        end
    end
`else
    // Unbuffered: ready is simply "shifter idle"; leaving IDLE drops it.
    assign command_ready_out = (state_q == IDLE);
    assign src_vld  = accept;
    assign src_byte = command_in;
    assign src_last = command_last_byte_in;
`endif

    ssd1306_spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_in       (clk_in),
        .rstn_in      (rstn_in),
        .run_i        (state_q != IDLE),
        .clear_i      (load || (state_d != state_q)),
        .phase_end_o  (phase_end),
        .sclk_phase_o (sclk_phase)
    );

    // SCLK is high only during SHIFT high phases since every state change clears the phase.
    assign oled_sclk = sclk_phase;
    assign oled_csn  = csn_q;
    assign oled_sdin = sdin_q;

    // Next-state: bit sequencing, CSn framing and shifter load decisions.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        csn_d   = csn_q;
        sdin_d  = sdin_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (src_vld) load = 1'b1;
            end
            SHIFT: begin
                if (phase_end && sclk_phase) begin
                    if (bit_q == 3'd0) begin
                        if (last_q)       state_d = HOLD;
                        else if (src_vld) load    = 1'b1;
                        else              state_d = IDLE;
                    end else begin
                        // Data moves only at the start of a low phase.
                        bit_d  = bit_q - 3'd1;
                        sdin_d = shreg_q[bit_q - 3'd1];
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = GAP;
                    csn_d   = 1'b1;
                end
            end
            GAP: begin
                if (phase_end) begin
                    if (src_vld) load    = 1'b1;
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = SHIFT;
            shreg_d = src_byte;
            last_d  = src_last;
            bit_d   = 3'd7;
            csn_d   = 1'b0;
            sdin_d  = src_byte[SPI_BYTE_BITS-1];
        end
    end

    // State and datapath registers; reset drops any in-flight byte.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= IDLE;
            bit_q   <= 3'd0;
            shreg_q <= '0;
            last_q  <= 1'b0;
            csn_q   <= 1'b1;
            sdin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            csn_q   <= csn_d;
            sdin_q  <= sdin_d;
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Directed bench for ssd1306_spi_tx. SDIN at every SCLK rise is checked
// against a queue of expected bits pushed when each byte is offered.
// Cycle k below means the value seen k clocks after the accept edge.
module tb_ssd1306_spi_tx;

`ifdef SSD1306_SPI_TX_BUFFER_EN
    localparam int D = 1;
`else
    localparam int D = 2;
`endif

    logic       clk_in = 1'b0;
    logic       rstn_in;
    logic       command_start_in;
    logic [7:0] command_in;
    logic       command_last_byte_in;
    logic       command_ready_out;
    logic       oled_csn;
    logic       oled_sclk;
    logic       oled_sdin;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];
    int   rise_t[$];
    int   cyc = 0;
    int   rise_cnt = 0;
    logic sclk_prev = 1'b0;

    always #5 clk_in = ~clk_in;

    ssd1306_spi_tx #(.CLK_DIV(D)) dut (
        .clk_in               (clk_in),
        .rstn_in              (rstn_in),
        .command_start_in     (command_start_in),
        .command_in           (command_in),
        .command_last_byte_in (command_last_byte_in),
        .command_ready_out    (command_ready_out),
        .oled_csn             (oled_csn),
        .oled_sclk            (oled_sclk),
        .oled_sdin            (oled_sdin)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bits(input logic [7:0] b, input int n);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < n; i++) exp_q.push_back(v[7 - i]);
    endtask

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    // Scoreboard consumer: every SCLK rise must match the next expected bit.
    always @(negedge clk_in) begin
        cyc++;
        if (oled_sclk === 1'b1 && sclk_prev === 1'b0) begin
            rise_cnt++;
            rise_t.push_back(cyc);
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sclk_rise: unexpected rise at cycle %0d, observed sdin %0b expected none", cyc, oled_sdin);
            end
            if (exp_q.size() != 0) begin
                logic e;
                e = exp_q.pop_front();
                assert (oled_sdin === e) else begin
                    n_fail++;
                    $error("FAIL sdin_bit: observed %0b expected %0b at cycle %0d", oled_sdin, e, cyc);
                end
            end
        end
        sclk_prev = oled_sclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r0, hi, csn_rise, bad;
        rstn_in = 1'b0;
        command_start_in = 1'b0;
        command_in = 8'h00;
        command_last_byte_in = 1'b0;
        step(); step();
        check("rst_csn", oled_csn, 1);
        check("rst_sclk", oled_sclk, 0);
        check("rst_sdin", oled_sdin, 0);
        check("rst_ready", command_ready_out, 1);
        rstn_in = 1'b1;

        // Idle after release: nothing moves for 100 cycles.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (oled_csn !== 1'b1 || oled_sclk !== 1'b0 || oled_sdin !== 1'b0 || command_ready_out !== 1'b1) bad++;
        end
        check("idle_100_bad_cycles", bad, 0);
        check("idle_no_rises", rise_cnt, 0);

`ifndef SSD1306_SPI_TX_BUFFER_EN
        // 0xAE, not last.
        command_in = 8'hAE; command_last_byte_in = 1'b0; command_start_in = 1'b1;
        push_bits(8'hAE, 8);
        step();
        check("ae_ready_low", command_ready_out, 0);
        check("ae_csn_low", oled_csn, 0);
        check("ae_sclk_low", oled_sclk, 0);
        check("ae_sdin_bit7", oled_sdin, 1);
        command_start_in = 1'b0;
        for (c = 2; c < 200; c++) begin
            step();
            if (command_ready_out === 1'b1) break;
        end
        check("ae_ready_cycle", c, 33);
        check("ae_csn_held", oled_csn, 0);
        check("ae_sclk_idle", oled_sclk, 0);
        check("ae_sb_empty", exp_q.size(), 0);

        // 0xAF, last: CSn framing with HOLD and GAP.
        command_in = 8'hAF; command_last_byte_in = 1'b1; command_start_in = 1'b1;
        push_bits(8'hAF, 8);
        step();
        check("af_csn_low", oled_csn, 0);
        command_start_in = 1'b0;
        hi = 0; csn_rise = 0;
        for (c = 2; c < 200; c++) begin
            step();
            if (command_ready_out === 1'b1) break;
            if (oled_csn === 1'b1) begin
                hi++;
                if (csn_rise == 0) csn_rise = c;
            end
        end
        check("af_csn_rise_cycle", csn_rise, 35);
        check("af_ready_cycle", c, 37);
        check("af_csn_high_before_ready", hi, 2);
        check("af_csn_idle_high", oled_csn, 1);
        check("af_sb_empty", exp_q.size(), 0);

        // Start held for 40 cycles: one byte, re-accept only once ready returns.
        command_in = 8'h5A; command_last_byte_in = 1'b0; command_start_in = 1'b1;
        push_bits(8'h5A, 8);
        push_bits(8'h5A, 8);
        r0 = rise_cnt;
        for (c = 1; c <= 40; c++) begin
            step();
            if (c == 32) check("hold_ready_low_32", command_ready_out, 0);
            if (c == 33) begin
                check("hold_one_byte_rises", rise_cnt - r0, 8);
                check("hold_ready_back", command_ready_out, 1);
            end
            if (c == 34) begin
                check("hold_second_accept", command_ready_out, 0);
                check("hold_second_sdin", oled_sdin, 0);
            end
        end
        command_start_in = 1'b0;
        for (c = 0; c < 200; c++) begin
            if (command_ready_out === 1'b1) break;
            step();
        end
        check("hold_ready_timeout", command_ready_out, 1);
        check("hold_total_rises", rise_cnt - r0, 16);
        check("hold_sb_empty", exp_q.size(), 0);

        // Reset during bit 3 (high phase) of 0x8D: only bits 7..3 rise.
        command_in = 8'h8D; command_last_byte_in = 1'b0; command_start_in = 1'b1;
        push_bits(8'h8D, 5);
        step();
        command_start_in = 1'b0;
        for (c = 2; c <= 19; c++) step();
        check("rst_mid_sclk_high", oled_sclk, 1);
        rstn_in = 1'b0;
        #1;
        check("rst_mid_csn", oled_csn, 1);
        check("rst_mid_sclk", oled_sclk, 0);
        check("rst_mid_sdin", oled_sdin, 0);
        step(); step();
        rstn_in = 1'b1;
        r0 = rise_cnt;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (command_ready_out !== 1'b1 || oled_csn !== 1'b1) bad++;
        end
        check("rst_after_bad_cycles", bad, 0);
        check("rst_after_no_rises", rise_cnt - r0, 0);
        check("rst_sb_empty", exp_q.size(), 0);
`else
        // Buffered, CLK_DIV=1: 0x20 then 0x00 back to back.
        rise_t.delete();
        command_in = 8'h20; command_last_byte_in = 1'b0; command_start_in = 1'b1;
        push_bits(8'h20, 8);
        step();
        check("buf_ready_low_c1", command_ready_out, 0);
        check("buf_csn_low", oled_csn, 0);
        command_start_in = 1'b0;
        step();
        check("buf_ready_high_c2", command_ready_out, 1);
        command_in = 8'h00; command_last_byte_in = 1'b1; command_start_in = 1'b1;
        push_bits(8'h00, 8);
        step();
        check("buf_full_ready_low", command_ready_out, 0);
        command_start_in = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("buf_rise_count", rise_t.size(), 16);
        bad = 0;
        for (int i = 1; i < rise_t.size(); i++)
            if (rise_t[i] - rise_t[i-1] != 2 * D) bad++;
        check("buf_rise_gaps", bad, 0);
        check("buf_csn_end_high", oled_csn, 1);
        check("buf_ready_end", command_ready_out, 1);
        check("buf_sb_empty", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
